// File: rtl/sha256_core_if.sv
// Host-side bus of the byte-serial SHA-256 engine: message byte stream in, digest prefix out.
// Handshake: a byte is transferred on every rising edge where load_enable is high; there is no ready, the core never stalls the host.
interface sha256_core_if;
    logic        load_enable;
    logic        input_complete;
    logic [7:0]  input_data;
    logic [15:0] hashed_data;

    modport master (
        output load_enable,
        output input_complete,
        output input_data,
        input  hashed_data
    );

    modport slave (
        input  load_enable,
        input  input_complete,
        input  input_data,
        output hashed_data
    );
endinterface

// File: rtl/sha256_core.sv
// Single-block SHA-256 engine: buffers up to 55 message bytes, pads, runs 64 rounds
// and publishes H0[31:16] of the digest.
module sha256_core (
    input  logic             clock,
    input  logic             reset,
    sha256_core_if.slave     bus,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAD    = 2'd1,
        ROUNDS = 2'd2,
        FINAL  = 2'd3
    } state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    count_q, count_d;
    logic [511:0]  buffer_q, buffer_d;
    logic [5:0]    round_q, round_d;
    logic [31:0]   wv_q [8];
    logic [31:0]   wv_d [8];
    logic [31:0]   hv_q [8];
    logic [31:0]   hv_d [8];
    logic [15:0]   hashed_q, hashed_d;
    logic          armed_q, armed_d;

    logic [8:0]    byte_shift;
    logic [31:0]   w0, w1, w9, w14, new_w;
    logic [31:0]   big_s0, big_s1, ch, maj, t1, t2;

    // The block buffer doubles as the 16-word schedule window: word 0 is W[t].
    assign w0  = buffer_q[511:480];
    assign w1  = buffer_q[479:448];
    assign w9  = buffer_q[223:192];
    assign w14 = buffer_q[63:32];
    assign new_w = (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + w9
                 + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w0;

    assign big_s1 = rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25);
    assign big_s0 = rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22);
    assign ch     = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
    assign maj    = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
    assign t1     = wv_q[7] + big_s1 + ch + K[round_q] + w0;
    assign t2     = big_s0 + maj;

    assign byte_shift = 9'd504 - {count_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        buffer_d = buffer_q;
        round_d  = round_q;
        wv_d     = wv_q;
        hv_d     = hv_q;
        hashed_d = hashed_q;
        armed_d  = armed_q;
        case (state_q)
            IDLE: begin
                if (bus.load_enable && (count_q < 6'd55)) begin
                    buffer_d = buffer_q | ({504'b0, bus.input_data} << byte_shift);
                    count_d  = count_q + 6'd1;
                end
                if (!bus.input_complete) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = PAD;
                end
            end
            PAD: begin
                buffer_d        = buffer_q | ({504'b0, 8'h80} << byte_shift);
                buffer_d[63:0]  = {55'b0, count_q, 3'b000};
                wv_d            = IV;
                round_d         = 6'd0;
                state_d         = ROUNDS;
            end
            ROUNDS: begin
                wv_d[7]  = wv_q[6];
                wv_d[6]  = wv_q[5];
                wv_d[5]  = wv_q[4];
                wv_d[4]  = wv_q[3] + t1;
                wv_d[3]  = wv_q[2];
                wv_d[2]  = wv_q[1];
                wv_d[1]  = wv_q[0];
                wv_d[0]  = t1 + t2;
                buffer_d = {buffer_q[479:0], new_w};
                round_d  = round_q + 6'd1;
                if (round_q == 6'd63) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    hv_d[i] = IV[i] + wv_q[i];
                end
                hashed_d = hv_d[0][31:16];
                count_d  = 6'd0;
                buffer_d = '0;
                // A strobe still held from the previous message must drop before it can start another hash.
                if (!bus.input_complete) begin
                    armed_d = 1'b1;
                end
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            buffer_q <= '0;
            round_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                wv_q[i] <= '0;
                hv_q[i] <= '0;
            end
            hashed_q <= '0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            buffer_q <= buffer_d;
            round_q  <= round_d;
            wv_q     <= wv_d;
            hv_q     <= hv_d;
            hashed_q <= hashed_d;
            armed_q  <= armed_d;
        end
    end

    assign bus.hashed_data = hashed_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_sha256_core.sv
// Directed bench for sha256_core: known digests, exact latency, reset abort and ignored inputs while busy.
module tb_sha256_core;

  logic        clock;
  logic        reset;
  logic [1:0]  state_dbg;
  sha256_core_if bus ();

  sha256_core dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  localparam logic [1:0] ST_IDLE = 2'd0;

  int n_tests;
  int n_fail;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load_msg(input string s, input bit same_cycle);
    for (int i = 0; i < s.len(); i++) begin
      bus.load_enable = 1'b1;
      bus.input_data  = s[i];
      if (same_cycle && i == s.len() - 1) bus.input_complete = 1'b1;
      tick();
    end
    bus.load_enable = 1'b0;
    if (!same_cycle || s.len() == 0) begin
      bus.input_complete = 1'b1;
      tick();
    end
    bus.input_complete = 1'b0;
  endtask

  // Strobe edge has just passed; result must appear exactly 66 edges later.
  task automatic wait_result(input string tag, input logic [15:0] prev);
    repeat (65) tick();
    check({tag, "_before"}, 32'(bus.hashed_data), 32'(prev));
    tick();
    check(tag, 32'(bus.hashed_data), 32'(exp_q.pop_front()));
    check({tag, "_idle"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  task automatic run_hash(input string tag, input string s, input bit same_cycle,
                          input logic [15:0] exp, input logic [15:0] prev);
    exp_q.push_back(exp);
    load_msg(s, same_cycle);
    wait_result(tag, prev);
    repeat (2) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.load_enable    = 1'b0;
    bus.input_complete = 1'b0;
    bus.input_data     = 8'h00;
    repeat (3) tick();
    check("rst_hash", 32'(bus.hashed_data), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b1;
    tick();

    run_hash("empty", "", 1'b0, 16'he3b0, 16'h0000);
    run_hash("abc", "abc", 1'b0, 16'hba78, 16'he3b0);
    run_hash("a_same_cycle", "a", 1'b1, 16'hca97, 16'hba78);

    // Inputs wiggled while busy must not disturb the hash nor start another.
    exp_q.push_back(16'hba78);
    load_msg("abc", 1'b0);
    for (int k = 0; k < 65; k++) begin
      bus.load_enable    = 1'($urandom_range(0, 1));
      bus.input_data     = 8'($urandom_range(0, 255));
      bus.input_complete = (k == 30 || k == 31);
      tick();
    end
    bus.load_enable    = 1'b0;
    bus.input_complete = 1'b0;
    check("disturb_before", 32'(bus.hashed_data), 32'hca97);
    tick();
    check("disturb", 32'(bus.hashed_data), 32'(exp_q.pop_front()));
    repeat (70) tick();
    check("disturb_no_rehash", 32'(state_dbg), 32'(ST_IDLE));
    check("disturb_hold", 32'(bus.hashed_data), 32'hba78);
    run_hash("a_after_disturb", "a", 1'b1, 16'hca97, 16'hba78);

    run_hash("fox", "The quick brown fox jumps over the lazy dog", 1'b0, 16'hd7a8, 16'hca97);
    run_hash("abc_after_fox", "abc", 1'b0, 16'hba78, 16'hd7a8);

    // Reset 20 cycles into ROUNDS.
    load_msg("abc", 1'b0);
    repeat (21) tick();
    #2 reset = 1'b0;
    #1;
    check("abort_hash", 32'(bus.hashed_data), 32'h0);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    reset = 1'b1;
    repeat (70) tick();
    check("abort_stays_zero", 32'(bus.hashed_data), 32'h0);
    check("abort_idle", 32'(state_dbg), 32'(ST_IDLE));
    run_hash("abc_after_abort", "abc", 1'b0, 16'hba78, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
